// File: rtl/sram_bus_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like bus between instruction fetch and data memory.
// Define SRAM_ARB_RR_EN to alternate the grant when both sides request; otherwise data always wins.
module sram_bus_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_size,
   input  logic [3:0]        d_sel,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_done,
   output logic              stallreq_from_if,
   output logic              stallreq_from_mem,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [3:0]        bus_wstrb,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [31:0]       bus_rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t state, state_nxt;
   logic   gnt_d;
   logic   i_elig, d_elig, pick_d, grant;

   // A side retiring on this edge must not be granted again with the same request.
   assign i_elig = i_req & ~i_done;
   assign d_elig = d_req & ~d_done;
   assign grant  = (state == IDLE) & (i_elig | d_elig);

`ifdef SRAM_ARB_RR_EN
   logic last_d;

   assign pick_d = d_elig & (~i_elig | ~last_d);

   always_ff @(posedge clk) begin
      if (rst)        last_d <= 1'b0;
      else if (grant) last_d <= pick_d;
   end
`else
   assign pick_d = d_elig;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_elig | d_elig) state_nxt = ADDR;
         ADDR:    if (bus_addr_ok)     state_nxt = DATA;
         DATA:    if (bus_data_ok)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus fields are frozen at grant so requester-side changes cannot disturb the transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_d     <= 1'b0;
         bus_wr    <= 1'b0;
         bus_size  <= 2'd0;
         bus_wstrb <= 4'd0;
         bus_addr  <= '0;
         bus_wdata <= 32'd0;
         i_rdata   <= 32'd0;
         d_rdata   <= 32'd0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         if (grant) begin
            gnt_d <= pick_d;
            if (pick_d) begin
               bus_wr    <= d_wr;
               bus_size  <= d_size;
               bus_wstrb <= d_wr ? d_sel : 4'd0;
               bus_addr  <= d_addr;
               bus_wdata <= d_wdata;
            end else begin
               bus_wr    <= 1'b0;
               bus_size  <= 2'd2;
               bus_wstrb <= 4'd0;
               bus_addr  <= i_addr;
               bus_wdata <= 32'd0;
            end
         end
         if ((state == DATA) && bus_data_ok) begin
            if (gnt_d) begin
               d_rdata <= bus_rdata;
               d_done  <= 1'b1;
            end else begin
               i_rdata <= bus_rdata;
               i_done  <= 1'b1;
            end
         end
      end
   end

   assign bus_req           = (state == ADDR);
   assign stallreq_from_if  = i_req & ~i_done;
   assign stallreq_from_mem = d_req & ~d_done;

endmodule
